pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Elastic single-clock pipeline stage with a two-entry skid buffer, placed directly upstream of the enable-gated data register (`data_dff`). It accepts words from the previous stage over a valid/ready handshake and presents them downstream. It drives the downstream register's enable so that a word is captured exactly on a completed transfer. It also registers backpressure, so `o_s_ready` has no combinational path from `i_m_ready`.

## Interface
- `DATA_W`, 32: payload width (matches the downstream register width, XLEN).
- `OUT_INIT`, 0: reset value of the main and skid data registers.
- `CNT_W`, 16: width of the transfer counter.

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_s_data`  in  DATA_W  upstream payload.
- `i_s_valid`  in  1  upstream word valid.
- `o_s_ready`  out  1  stage can accept a word (registered).
- `o_m_data`  out  DATA_W  payload to the downstream register's d input.
- `o_m_valid`  out  1  `o_m_data` is valid (registered).
- `i_m_ready`  in  1  downstream accepts a word.
- `o_register_en`  out  1  enable for the downstream register; equals `o_m_valid & i_m_ready`.
- `o_occupancy`  out  2  words held: 0, 1 or 2.
- `o_xfer_cnt`  out  CNT_W  completed output transfers, modulo 2^CNT_W.

## Operation
- Input fire: `in_fire = i_s_valid & o_s_ready`.
- Output fire: `out_fire = o_m_valid & i_m_ready`.
- Storage: a main register drives `o_m_data`; a skid register holds one extra word.

State machine (state value equals `o_occupancy`):
- **EMPTY (0)**
  - `in_fire`: main <= `i_s_data`; go to BUSY.
  - Otherwise: stay in EMPTY.
- **BUSY (1)**
  - `in_fire & out_fire`: main <= `i_s_data`; stay in BUSY.
  - `in_fire & !out_fire`: skid <= `i_s_data`; go to FULL.
  - `!in_fire & out_fire`: go to EMPTY.
  - Otherwise: hold.
- **FULL (2)**
  - `out_fire`: main <= skid; go to BUSY. `in_fire` cannot occur here because `o_s_ready` = 0.
  - Otherwise: hold.

Output and handshake rules:
- `o_m_valid` = (state != EMPTY).
- `o_s_ready` is a register, loaded each cycle with (next_state != FULL).
- Words leave in strict arrival order. No word is dropped or duplicated.
- `i_s_valid` while `o_s_ready` = 0 is ignored; upstream must hold its word.
- `i_s_data` is ignored while `i_s_valid` = 0.
- While `o_m_valid` = 1 and `i_m_ready` = 0, `o_m_data` and `o_m_valid` are stable.
- `o_xfer_cnt` increments by 1 on every `out_fire` and wraps from 2^CNT_W−1 to 0.
- Skid contents are don't-care when state != FULL and are never presented on the output.

Reset (`i_rst` = 1 at a clock edge, including mid-transfer):
- State = EMPTY.
- `o_m_valid` = 0 and `o_s_ready` = 0.
- Main and skid registers = `OUT_INIT`; `o_m_data` = `OUT_INIT`.
- `o_occupancy` = 0 and `o_xfer_cnt` = 0.
- All held words are discarded, and no `o_register_en` pulse is produced for them.
- Handshakes presented during reset are ignored.

## Timing
- Latency: a word accepted at edge N appears on `o_m_data` with `o_m_valid` = 1 after edge N.
- Throughput: 1 word/cycle sustained when `i_m_ready` = 1.
- `o_s_ready` first rises one cycle after the first edge where `i_rst` = 0.
- Backpressure: `o_s_ready` falls the cycle after a stall fills the skid register. Exactly one extra word is absorbed after `i_m_ready` drops.
- Recovery: `o_s_ready` returns to 1 the cycle after the `out_fire` that drains the skid.
- Registered outputs: `o_s_ready`, `o_m_valid`, `o_m_data`, `o_occupancy`, `o_xfer_cnt`.
- `o_register_en` is combinational from `o_m_valid` and `i_m_ready`. The downstream register therefore captures `o_m_data` on the same edge as `out_fire`.

## Test plan
- **Reset release:** hold `i_rst` = 1 for 3 cycles with `i_s_valid` = 1. Required: `o_m_valid` = 0, `o_s_ready` = 0, `o_m_data` = `OUT_INIT` and `o_xfer_cnt` = 0 throughout. `o_s_ready` = 1 exactly one cycle after release.
- **Streaming:** `i_m_ready` = 1; send 0x11, 0x22, 0x33 on consecutive cycles. Required:
  - Each word appears on `o_m_data` one cycle after acceptance.
  - `o_register_en` is high for 3 consecutive cycles.
  - `o_xfer_cnt` = 3 and `o_occupancy` ends at 0.
- **Stall/skid:** stream 0xA0, 0xA1, 0xA2 with `i_m_ready` = 0 from the first cycle. Required:
  - 0xA0 and 0xA1 are accepted, and `o_occupancy` = 2.
  - `o_s_ready` = 0, so 0xA2 is held upstream.
  - After `i_m_ready` = 1, the output order is 0xA0, 0xA1, 0xA2 with no loss.
- **Simultaneous fire in BUSY:** state BUSY holding 0x5; `in_fire` with 0x6 and `out_fire` on the same cycle. Required: 0x5 transfers, `o_m_data` = 0x6 next cycle, `o_occupancy` stays 1.
- **Counter wrap:** set `CNT_W` = 4 and perform 17 transfers. Required: `o_xfer_cnt` reads 15 after the 15th transfer, 0 after the 16th, and 1 after the 17th.
- **Reset mid-operation:** reach FULL with 0xB0, 0xB1; assert `i_rst` for 1 cycle. Required: `o_occupancy` = 0, `o_m_valid` = 0, `o_xfer_cnt` = 0. Neither 0xB0 nor 0xB1 is ever output afterwards.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
// Elastic valid/ready pipeline stage with a two-entry skid buffer. The main
// register drives the downstream data register; a skid register absorbs the
// one extra word that arrives after the downstream side stalls, so the
// upstream ready can be a flop with no combinational path from i_m_ready.
// o_register_en strobes the downstream register exactly on a completed
// output transfer.

module pipe_skid_stage #(
   parameter int unsigned       DATA_W   = 32,
   parameter logic [DATA_W-1:0] OUT_INIT = '0,
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_s_data,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic              o_register_en,
   output logic [1:0]        o_occupancy,
   output logic [CNT_W-1:0]  o_xfer_cnt
);

   // State encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic              r_m_valid;
   logic              r_s_ready;
   logic [CNT_W-1:0]  r_xfer_cnt;

   logic              w_in_fire;
   logic              w_out_fire;

   assign w_in_fire  = i_s_valid & r_s_ready;
   assign w_out_fire = r_m_valid & i_m_ready;

   // Next occupancy from the two handshakes.
   always_comb begin
      // NOTE: default assignment first so every path assigns w_next_state and no latch is inferred.
      w_next_state = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) w_next_state = ST_BUSY;
         end
         ST_BUSY: begin
            if (w_in_fire && !w_out_fire)      w_next_state = ST_FULL;
            else if (!w_in_fire && w_out_fire) w_next_state = ST_EMPTY;
         end
         ST_FULL: begin
            // Upstream is held off in FULL, so only a drain can happen here.
            if (w_out_fire) w_next_state = ST_BUSY;
         end
         default: w_next_state = ST_EMPTY;
      endcase
   end

   // State, registered handshake outputs, data movement and transfer count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
         r_state    <= ST_EMPTY;
         r_m_valid  <= 1'b0;
         r_s_ready  <= 1'b0;
         r_main     <= OUT_INIT;
         r_skid     <= OUT_INIT;
         r_xfer_cnt <= '0;
      end else begin
         r_state   <= w_next_state;
         r_m_valid <= (w_next_state != ST_EMPTY);
         // Ready is computed from the next state, so it drops on the edge that fills the skid.
         r_s_ready <= (w_next_state != ST_FULL);

         if (w_out_fire) r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);

         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) r_main <= i_s_data;
            end
            ST_BUSY: begin
               // With both sides firing the main word leaves and the new one replaces it.
               if (w_in_fire && w_out_fire) r_main <= i_s_data;
               else if (w_in_fire)          r_skid <= i_s_data;
            end
            ST_FULL: begin
               if (w_out_fire) r_main <= r_skid;
            end
            default: ;
         endcase
      end
   end

   assign o_s_ready     = r_s_ready;
   assign o_m_valid     = r_m_valid;
   assign o_m_data      = r_main;
   assign o_register_en = w_out_fire;
   assign o_occupancy   = r_state;
   assign o_xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage
// Directed bench for pipe_skid_stage. A negedge monitor keeps a scoreboard
// queue of accepted words plus a reference occupancy/ready/count model and
// compares every cycle; the directed sequence checks the named scenarios.

module tb_pipe_skid_stage;

   localparam int unsigned       DATA_W   = 32;
   localparam int unsigned       CNT_W    = 4;
   localparam logic [DATA_W-1:0] OUT_INIT = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              register_en;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  xfer_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard and reference model state, owned by the monitor.
   logic [DATA_W-1:0] sb_q[$];
   logic              model_ok  = 1'b0;
   logic              exp_ready = 1'b0;
   logic [CNT_W-1:0]  exp_cnt   = '0;

   pipe_skid_stage #(
      .DATA_W  (DATA_W),
      .OUT_INIT(OUT_INIT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_s_data     (s_data),
      .i_s_valid    (s_valid),
      .o_s_ready    (s_ready),
      .o_m_data     (m_data),
      .o_m_valid    (m_valid),
      .i_m_ready    (m_ready),
      .o_register_en(register_en),
      .o_occupancy  (occupancy),
      .o_xfer_cnt   (xfer_cnt)
   );

   // 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 2 units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Per-cycle scoreboard/model compare, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      logic do_in, do_out;
      if (model_ok) begin
         check("mon_occupancy", 64'(occupancy), 64'(sb_q.size()));
         check("mon_m_valid",   64'(m_valid),   64'(sb_q.size() != 0));
         check("mon_s_ready",   64'(s_ready),   64'(exp_ready));
         check("mon_xfer_cnt",  64'(xfer_cnt),  64'(exp_cnt));
         check("mon_reg_en",    64'(register_en), 64'((sb_q.size() != 0) && m_ready));
         if (sb_q.size() != 0) check("mon_m_data", 64'(m_data), 64'(sb_q[0]));
      end
      if (rst) begin
         model_ok  = 1'b1;
         sb_q.delete();
         exp_ready = 1'b0;
         exp_cnt   = '0;
      end else if (model_ok) begin
         do_out = (sb_q.size() != 0) && m_ready;
         do_in  = s_valid && exp_ready;
         if (do_out) begin
            void'(sb_q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
         end
         if (do_in) sb_q.push_back(s_data);
         exp_ready = (sb_q.size() != 2);
      end
   end

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'h99;
      m_ready = 1'b0;

      // Reset release: three reset cycles with upstream valid held high.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_m_valid",  64'(m_valid),  64'(0));
         check("rst_s_ready",  64'(s_ready),  64'(0));
         check("rst_m_data",   64'(m_data),   64'(OUT_INIT));
         check("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
      end
      rst     = 1'b0;
      s_valid = 1'b0;
      tick();
      check("rel_s_ready_1", 64'(s_ready), 64'(1));
      check("rel_m_valid",   64'(m_valid), 64'(0));

      // Streaming: three back-to-back words with downstream always ready.
      m_ready = 1'b1;
      check("str_en_idle", 64'(register_en), 64'(0));
      s_valid = 1'b1; s_data = 32'h11;
      tick();
      check("str_d0", 64'(m_data), 64'h11);
      check("str_en0", 64'(register_en), 64'(1));
      s_data = 32'h22;
      tick();
      check("str_d1", 64'(m_data), 64'h22);
      check("str_en1", 64'(register_en), 64'(1));
      s_data = 32'h33;
      tick();
      check("str_d2", 64'(m_data), 64'h33);
      check("str_en2", 64'(register_en), 64'(1));
      s_valid = 1'b0;
      tick();
      check("str_en_end", 64'(register_en), 64'(0));
      check("str_occ", 64'(occupancy), 64'(0));
      check("str_cnt", 64'(xfer_cnt), 64'(3));

      // Stall/skid: downstream stalled from the first word.
      m_ready = 1'b0;
      s_valid = 1'b1; s_data = 32'hA0;
      tick();
      check("stl_occ1", 64'(occupancy), 64'(1));
      s_data = 32'hA1;
      tick();
      check("stl_occ2", 64'(occupancy), 64'(2));
      check("stl_ready0", 64'(s_ready), 64'(0));
      s_data = 32'hA2;
      tick();
      check("stl_hold_occ", 64'(occupancy), 64'(2));
      check("stl_hold_data", 64'(m_data), 64'hA0);
      m_ready = 1'b1;
      tick();
      check("stl_d1", 64'(m_data), 64'hA1);
      check("stl_ready1", 64'(s_ready), 64'(1));
      tick();
      check("stl_d2", 64'(m_data), 64'hA2);
      s_valid = 1'b0;
      tick();
      check("stl_occ_end", 64'(occupancy), 64'(0));
      check("stl_cnt", 64'(xfer_cnt), 64'(6));

      // Simultaneous in/out fire while BUSY.
      m_ready = 1'b0;
      s_valid = 1'b1; s_data = 32'h5;
      tick();
      check("sim_busy_occ", 64'(occupancy), 64'(1));
      check("sim_busy_data", 64'(m_data), 64'h5);
      s_data  = 32'h6;
      m_ready = 1'b1;
      tick();
      check("sim_data", 64'(m_data), 64'h6);
      check("sim_occ", 64'(occupancy), 64'(1));
      check("sim_cnt", 64'(xfer_cnt), 64'(7));
      s_valid = 1'b0;
      tick();
      check("sim_cnt_end", 64'(xfer_cnt), 64'(8));

      // Counter wrap: transfers 9..17 on a 4-bit counter.
      s_valid = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         s_data = 32'h100 + 32'(j);
         tick();
         if (j == 8) check("wrap_15", 64'(xfer_cnt), 64'(15));
         if (j == 9) check("wrap_0",  64'(xfer_cnt), 64'(0));
      end
      s_valid = 1'b0;
      tick();
      check("wrap_1", 64'(xfer_cnt), 64'(1));

      // Reset mid-operation with the stage FULL.
      m_ready = 1'b0;
      s_valid = 1'b1; s_data = 32'hB0;
      tick();
      s_data = 32'hB1;
      tick();
      check("mid_full", 64'(occupancy), 64'(2));
      rst = 1'b1;
      tick();
      check("mid_occ",   64'(occupancy), 64'(0));
      check("mid_valid", 64'(m_valid),   64'(0));
      check("mid_cnt",   64'(xfer_cnt),  64'(0));
      check("mid_data",  64'(m_data),    64'(OUT_INIT));
      check("mid_ready", 64'(s_ready),   64'(0));
      check("mid_en",    64'(register_en), 64'(0));
      rst     = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_no_old_valid", 64'(m_valid), 64'(0));
      end
      s_valid = 1'b1; s_data = 32'hC0;
      tick();
      check("mid_new_data", 64'(m_data), 64'hC0);
      s_valid = 1'b0;
      tick();
      check("mid_new_cnt", 64'(xfer_cnt), 64'(1));

      tick();
      tick();
      check("sb_drained", 64'(sb_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
